// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter able to hold 0..max_burst.
  function automatic int unsigned cnt_bits(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo.sv
// First-word-fall-through FIFO: rd_data shows the head whenever ready_rd is high.
module fifo
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned SIZE      = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 ready_wr,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 ready_rd
);

  localparam int unsigned PW = idx_bits(SIZE);
  localparam int unsigned CW = $clog2(SIZE + 1);

  logic [DATA_BITS-1:0] mem [SIZE];
  logic [PW-1:0]        wp;
  logic [PW-1:0]        rp;
  logic [CW-1:0]        count;
  logic                 do_wr;
  logic                 do_rd;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status flags, gated handshakes and head-of-queue read.
  always_comb begin
    ready_wr = (count != CW'(SIZE));
    ready_rd = (count != '0);
    do_wr    = wr && ready_wr;
    do_rd    = rd && ready_rd;
    rd_data  = mem[rp];
  end

  // Pointer and occupancy tracking; reset flushes the contents.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= ptr_next(wp);
      if (do_rd) rp <= ptr_next(rp);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end

  // Storage array, no reset needed since occupancy gates visibility.
  always_ff @(posedge aclk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/rr_pick.sv
// Finds the first set bit of nonempty at or after ptr, wrapping modulo N_SRC.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned IDX_BITS = idx_bits(N_SRC)
) (
  input  logic [N_SRC-1:0]    nonempty,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                found,
  output logic [IDX_BITS-1:0] index
);

  logic [IDX_BITS:0]   sum;
  logic [IDX_BITS-1:0] cand;

  // Scan candidates in rotated priority order, keeping the first hit.
  always_comb begin
    found = 1'b0;
    index = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      sum = {1'b0, ptr} + (IDX_BITS + 1)'(off);
      if (sum >= (IDX_BITS + 1)'(N_SRC)) sum = sum - (IDX_BITS + 1)'(N_SRC);
      cand = sum[IDX_BITS-1:0];
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Per-source FWFT buffers drained onto one stream by a round-robin burst scheduler.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned FIFO_SIZE = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_SRC-1:0]             s_valid,
  output logic [N_SRC-1:0]             s_ready,
  input  logic [N_SRC*DATA_BITS-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_BITS-1:0]         m_data,
  output logic [idx_bits(N_SRC)-1:0]   m_src
);

  localparam int unsigned IDX_BITS = idx_bits(N_SRC);
  localparam int unsigned CNT_BITS = cnt_bits(MAX_BURST);

  state_t               state;
  logic [IDX_BITS-1:0]  grant;
  logic [IDX_BITS-1:0]  rr_ptr;
  logic [CNT_BITS-1:0]  beat_cnt;

  logic [N_SRC-1:0]     nonempty;
  logic [N_SRC-1:0]     pop;
  logic [DATA_BITS-1:0] head [N_SRC];
  logic                 pick_found;
  logic [IDX_BITS-1:0]  pick_idx;
  logic                 hs;
  logic                 last_beat;
  logic [IDX_BITS-1:0]  next_ptr;

  for (genvar i = 0; i < N_SRC; i++) begin : g_buf
    fifo #(
      .DATA_BITS (DATA_BITS),
      .SIZE      (FIFO_SIZE)
    ) u_fifo (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .wr       (s_valid[i]),
      .wr_data  (s_data[i*DATA_BITS +: DATA_BITS]),
      .ready_wr (s_ready[i]),
      .rd       (pop[i]),
      .rd_data  (head[i]),
      .ready_rd (nonempty[i])
    );
  end

  rr_pick #(
    .N_SRC    (N_SRC),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .nonempty (nonempty),
    .ptr      (rr_ptr),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // Output stream view of the granted buffer and pop decode.
  always_comb begin
    m_valid   = (state == BURST) && nonempty[grant];
    m_src     = (state == BURST) ? grant : '0;
    m_data    = m_valid ? head[grant] : '0;
    hs        = m_valid && m_ready;
    pop       = '0;
    if (hs) pop[grant] = 1'b1;
    last_beat = (beat_cnt == CNT_BITS'(MAX_BURST - 1));
    next_ptr  = (grant == IDX_BITS'(N_SRC - 1)) ? '0 : grant + IDX_BITS'(1);
  end

  // Grant/burst scheduler: one IDLE bubble between bursts, rotate after each.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (!m_valid) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (hs) begin
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end else begin
              beat_cnt <= beat_cnt + CNT_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
